// File: rtl/ram_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the shared RAM and the arbiter.
// The arbiter takes the slave view; the bench (requesters + RAM model) takes the master view.
interface ram_arbiter_if;
    logic        iren;
    logic [31:0] imemaddr;
    logic        dren;
    logic        dwen;
    logic [31:0] dmmaddr;
    logic [31:0] dmmstore;
    logic        busy_o;
    logic [31:0] ramload;
    logic        Ren;
    logic        Wen;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic        ihit;
    logic [31:0] imemload;
    logic        dhit;
    logic [31:0] dmmload;
    logic        err;

    modport slave (
        input  iren, imemaddr, dren, dwen, dmmaddr, dmmstore, busy_o, ramload,
        output Ren, Wen, ramaddr, ramstore, ihit, imemload, dhit, dmmload, err
    );

    modport master (
        output iren, imemaddr, dren, dwen, dmmaddr, dmmstore, busy_o, ramload,
        input  Ren, Wen, ramaddr, ramstore, ihit, imemload, dhit, dmmload, err
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester arbiter for a single-port RAM: fetch and data sides alternate when
// both are pending, each access ends in a one-cycle hit pulse, and a stuck RAM is timed out.
module ram_arbiter (
    input  logic          CLK,
    input  logic          nRST,
    ram_arbiter_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, IREQ, DREQ, IRESP, DRESP} state_t;

    state_t      state_q, state_d;
    logic        last_d_q, last_d_d;   // 1 = data side won the most recent grant
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wr_q, wr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] imemload_q, imemload_d;
    logic [31:0] dmmload_q, dmmload_d;

    logic dreq, pick_d, active;

    assign dreq   = bus.dren | bus.dwen;
    assign pick_d = dreq & (~bus.iren | ~last_d_q);
    assign active = (state_q == IREQ) || (state_q == DREQ);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            last_d_q   <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_q       <= 1'b0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            imemload_q <= '0;
            dmmload_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_d_q   <= last_d_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wr_q       <= wr_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            imemload_q <= imemload_d;
            dmmload_q  <= dmmload_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d_d   = last_d_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wr_d       = wr_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        imemload_d = imemload_q;
        dmmload_d  = dmmload_q;
        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    state_d  = DREQ;
                    last_d_d = 1'b1;
                    addr_d   = bus.dmmaddr;
                    wdata_d  = bus.dmmstore;
                    wr_d     = bus.dwen;
                    cnt_d    = '0;
                    err_d    = 1'b0;
                end else if (bus.iren) begin
                    state_d  = IREQ;
                    last_d_d = 1'b0;
                    addr_d   = bus.imemaddr;
                    wdata_d  = '0;
                    wr_d     = 1'b0;
                    cnt_d    = '0;
                    err_d    = 1'b0;
                end
            end
            IREQ, DREQ: begin
                if (!bus.busy_o) begin
                    if (!wr_q && state_q == IREQ) imemload_d = bus.ramload;
                    if (!wr_q && state_q == DREQ) dmmload_d  = bus.ramload;
                    state_d = (state_q == IREQ) ? IRESP : DRESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    // Abort on the busy cycle that takes the counter to 255.
                    if (cnt_q == 8'd254) begin
                        err_d   = 1'b1;
                        state_d = (state_q == IREQ) ? IRESP : DRESP;
                    end
                end
            end
            IRESP, DRESP: state_d = IDLE;
            default:      state_d = IDLE;
        endcase
    end

    assign bus.Ren      = active & ~wr_q;
    assign bus.Wen      = active &  wr_q;
    assign bus.ramaddr  = active ? addr_q  : '0;
    assign bus.ramstore = active ? wdata_q : '0;
    assign bus.ihit     = (state_q == IRESP);
    assign bus.dhit     = (state_q == DRESP);
    assign bus.err      = ((state_q == IRESP) || (state_q == DRESP)) & err_q;
    assign bus.imemload = imemload_q;
    assign bus.dmmload  = dmmload_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed + randomized check of ram_arbiter against a transaction-level model of
// grant order, access length, captured data and timeout behaviour.
module tb_ram_arbiter;
    logic CLK = 1'b0;
    logic nRST;
    ram_arbiter_if bus();

    ram_arbiter dut (.CLK(CLK), .nRST(nRST), .bus(bus.slave));

    always #5 CLK = ~CLK;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_imem = '0;
    logic [31:0] exp_dmm  = '0;
    bit          last_d   = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Starts in IDLE with requests already on the bus; runs one access to its hit
    // and returns in the following IDLE cycle. busy_n = busy cycles before ready.
    task automatic txn(input int busy_n, input bit drop, input logic [31:0] rdata,
                       output bit side_d);
        bit          wr, abort;
        int          req_len;
        logic [31:0] a, s;
        chk("idle_ren",  bus.Ren, 0);
        chk("idle_wen",  bus.Wen, 0);
        chk("idle_addr", bus.ramaddr, 0);
        if (bus.iren && (bus.dren || bus.dwen)) side_d = !last_d;
        else                                    side_d = !bus.iren;
        last_d  = side_d;
        wr      = side_d && bus.dwen;
        a       = side_d ? bus.dmmaddr : bus.imemaddr;
        s       = bus.dmmstore;
        abort   = (busy_n >= 255);
        req_len = abort ? 255 : busy_n + 1;
        bus.busy_o  = 1'b1;
        bus.ramload = $urandom;
        tick();
        for (int k = 0; k < req_len; k++) begin
            chk("req_ren",  bus.Ren, {31'b0, !wr});
            chk("req_wen",  bus.Wen, {31'b0, wr});
            chk("req_addr", bus.ramaddr, a);
            if (side_d) chk("req_store", bus.ramstore, s);
            chk("req_nohit", {bus.ihit, bus.dhit}, 0);
            if (k == 0 && drop) begin
                if (side_d) begin bus.dren = 0; bus.dwen = 0; end
                else bus.iren = 0;
            end
            bus.busy_o  = (k < busy_n);
            bus.ramload = bus.busy_o ? $urandom : rdata;
            tick();
        end
        if (!abort && !wr) begin
            if (side_d) exp_dmm = rdata;
            else        exp_imem = rdata;
        end
        chk("resp_ihit", bus.ihit, {31'b0, !side_d});
        chk("resp_dhit", bus.dhit, {31'b0, side_d});
        chk("resp_err",  bus.err,  {31'b0, abort});
        chk("resp_ren",  {bus.Ren, bus.Wen}, 0);
        chk("imemload",  bus.imemload, exp_imem);
        chk("dmmload",   bus.dmmload,  exp_dmm);
        if (side_d) begin bus.dren = 0; bus.dwen = 0; end
        else bus.iren = 0;
        bus.busy_o = $urandom_range(0, 1);
        tick();
        chk("post_hit", {bus.ihit, bus.dhit, bus.err}, 0);
    endtask

    initial begin
        bit side;
        nRST = 1'b0;
        bus.iren = 0; bus.imemaddr = '0; bus.dren = 0; bus.dwen = 0;
        bus.dmmaddr = '0; bus.dmmstore = '0; bus.busy_o = 0; bus.ramload = '0;
        #12;
        chk("rst_ctl",   {bus.Ren, bus.Wen, bus.ihit, bus.dhit, bus.err}, 0);
        chk("rst_addr",  bus.ramaddr, 0);
        chk("rst_store", bus.ramstore, 0);
        chk("rst_iload", bus.imemload, 0);
        chk("rst_dload", bus.dmmload, 0);
        tick();
        nRST = 1'b1;
        tick();

        // Both sides at once after reset: fetch first, then data.
        bus.iren = 1; bus.imemaddr = 32'h0000_1000;
        bus.dren = 1; bus.dmmaddr  = 32'h0000_2000; bus.dmmstore = 32'h5555_AAAA;
        txn(0, 0, 32'hCAFE_0001, side);
        chk("first_side_i", {31'b0, side}, 0);
        txn(1, 0, 32'hDA7A_0002, side);
        chk("second_side_d", {31'b0, side}, 1);

        // Minimum-latency fetch.
        bus.iren = 1; bus.imemaddr = 32'hABCD_ABCD;
        txn(0, 0, 32'h1234_1234, side);

        // Write with dren also high, three busy cycles.
        bus.dwen = 1; bus.dren = 1; bus.dmmaddr = 32'hABCD_ABCD; bus.dmmstore = 32'h3333_3333;
        txn(3, 0, 32'hDEAD_BEEF, side);

        // Stuck RAM during a fetch: timeout.
        bus.iren = 1; bus.imemaddr = 32'h0BAD_0BAD;
        txn(300, 0, 32'hFFFF_0000, side);

        // Request dropped mid-access still completes.
        bus.dren = 1; bus.dmmaddr = 32'h0000_0040;
        txn(2, 1, 32'h0D0D_0D0D, side);

        // Continuous contention alternates sides.
        for (int n = 0; n < 4; n++) begin
            bus.iren = 1; bus.imemaddr = 32'h1000_0000 + n;
            bus.dren = 1; bus.dmmaddr  = 32'h2000_0000 + n;
            txn(n % 2, 0, 32'h7700_0000 + n, side);
            chk("alternate", {31'b0, side}, {31'b0, !side_prev(n)});
        end
        bus.iren = 0; bus.dren = 0;
        tick();

        // Reset in the middle of a data access.
        bus.dren = 1; bus.dmmaddr = 32'h0000_0ABC; bus.busy_o = 1;
        tick();
        tick();
        chk("dreq_active", bus.Ren, 1);
        #2 nRST = 1'b0;
        #1;
        chk("rst_mid_ctl",   {bus.Ren, bus.Wen}, 0);
        chk("rst_mid_addr",  bus.ramaddr, 0);
        chk("rst_mid_dload", bus.dmmload, 0);
        bus.dren = 0; bus.busy_o = 0;
        exp_imem = '0; exp_dmm = '0; last_d = 1'b1;
        tick();
        nRST = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("rst_nohit", {bus.ihit, bus.dhit, bus.err}, 0);
        end
        bus.iren = 1; bus.imemaddr = 32'h0000_0F00;
        txn(1, 0, 32'h600D_F00D, side);

        // Random traffic; a pending request stays up until its hit.
        for (int n = 0; n < 40; n++) begin
            bit ni, nd;
            ni = !bus.iren && ($urandom_range(0, 1) == 1);
            nd = !(bus.dren || bus.dwen) && ($urandom_range(0, 1) == 1);
            if (!bus.iren && !(bus.dren || bus.dwen) && !ni && !nd) ni = 1;
            if (ni) begin bus.iren = 1; bus.imemaddr = $urandom; end
            if (nd) begin
                int rw;
                rw = $urandom_range(0, 2);
                bus.dmmaddr = $urandom; bus.dmmstore = $urandom;
                bus.dren = (rw != 1); bus.dwen = (rw != 0);
            end
            txn($urandom_range(0, 4), $urandom_range(0, 3) == 0, $urandom, side);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Sides in the contention loop follow I,D,I,D after a data grant.
    function automatic bit side_prev(input int n);
        return (n % 2 == 0);
    endfunction
endmodule
